// File: rtl/cvp14_pkg.sv
// Shared types and constants for the system-memory port arbiter.
package cvp14_pkg;

  localparam int BURST_LEN = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_FWAIT  = 3'd2,
    ST_VBURST = 3'd3,
    ST_VDRAIN = 3'd4
  } arbState_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_V  = 1'b1
  } reqId_t;

endpackage

// File: rtl/burst_beat_counter.sv
// Beat counter for vector bursts: synchronous clear, count enable, all-ones terminal flag.
module burst_beat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             Clk1,
  input  logic             Reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  always_ff @(posedge Clk1) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = &count;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer sharing the system-memory port between
// single-word instruction fetches and fixed-length vector bursts.
module mem_port_arbiter
  import cvp14_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int BURST = BURST_LEN,
  localparam int BW   = $clog2(BURST)
) (
  input  logic          Clk1,
  input  logic          Reset,
  input  logic          IfReq,
  input  logic [AW-1:0] IfAddr,
  output logic          IfGnt,
  output logic          IfValid,
  input  logic          VReq,
  input  logic          VWr,
  input  logic [AW-1:0] VBase,
  output logic          VGnt,
  output logic [BW-1:0] VBeat,
  input  logic [DW-1:0] VWData,
  output logic          VRValid,
  output logic [BW-1:0] VRBeat,
  output logic          VDone,
  output logic [DW-1:0] RData,
  output logic [AW-1:0] Addr,
  output logic          RD,
  output logic          WR,
  output logic [DW-1:0] DataOut,
  input  logic [DW-1:0] DataIn
);

  arbState_t     state;
  reqId_t        lastReq;
  logic [AW-1:0] vBaseLatched;
  logic          vWrLatched;
  logic          capPending;
  logic [BW-1:0] capBeat;

  logic [BW-1:0] beatCnt;
  logic          beatTc;
  logic [BW-1:0] nextBeat;

  burst_beat_counter #(.WIDTH(BW)) beatCounter (
    .Clk1     (Clk1),
    .Reset    (Reset),
    .clear    (state != ST_VBURST),
    .enable   (state == ST_VBURST),
    .count    (beatCnt),
    .terminal (beatTc)
  );

  assign nextBeat = beatCnt + 1'b1;
  assign VBeat    = (state == ST_VBURST) ? beatCnt : '0;
  assign DataOut  = WR ? VWData : '0;

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state        <= ST_IDLE;
      lastReq      <= REQ_V;
      vBaseLatched <= '0;
      vWrLatched   <= 1'b0;
      capPending   <= 1'b0;
      capBeat      <= '0;
      Addr         <= '0;
      RD           <= 1'b0;
      WR           <= 1'b0;
      RData        <= '0;
      IfGnt        <= 1'b0;
      IfValid      <= 1'b0;
      VGnt         <= 1'b0;
      VRValid      <= 1'b0;
      VRBeat       <= '0;
      VDone        <= 1'b0;
    end else begin
      IfGnt      <= 1'b0;
      VGnt       <= 1'b0;
      IfValid    <= 1'b0;
      VDone      <= 1'b0;
      VRValid    <= 1'b0;
      capPending <= 1'b0;

      // Load beats land on DataIn one cycle after issue; capture them here.
      if (capPending) begin
        RData   <= DataIn;
        VRValid <= 1'b1;
        VRBeat  <= capBeat;
      end

      case (state)
        ST_IDLE: begin
          if (IfReq && (!VReq || lastReq == REQ_V)) begin
            state   <= ST_FETCH;
            Addr    <= IfAddr;
            RD      <= 1'b1;
            IfGnt   <= 1'b1;
            lastReq <= REQ_IF;
          end else if (VReq) begin
            state        <= ST_VBURST;
            Addr         <= VBase;
            vBaseLatched <= VBase;
            vWrLatched   <= VWr;
            RD           <= !VWr;
            WR           <= VWr;
            VGnt         <= 1'b1;
            lastReq      <= REQ_V;
          end
        end
        ST_FETCH: begin
          RD    <= 1'b0;
          state <= ST_FWAIT;
        end
        ST_FWAIT: begin
          RData   <= DataIn;
          IfValid <= 1'b1;
          state   <= ST_IDLE;
        end
        ST_VBURST: begin
          if (!vWrLatched) begin
            capPending <= 1'b1;
            capBeat    <= beatCnt;
          end
          if (beatTc) begin
            RD <= 1'b0;
            WR <= 1'b0;
            if (vWrLatched) begin
              VDone <= 1'b1;
              state <= ST_IDLE;
            end else begin
              state <= ST_VDRAIN;
            end
          end else begin
            Addr <= vBaseLatched + AW'(nextBeat);
          end
        end
        ST_VDRAIN: begin
          VDone <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
